// File: rtl/digit_entry_sequencer.sv
// Answer-entry front end: synchronizes the enter button, detects presses and strobes sw into
// the per-digit load registers in slot order. Define DIGIT_ENTRY_DEBOUNCE_EN to enable debouncing.
module digit_entry_sequencer #(
  parameter int unsigned NUM_DIGITS      = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  clear,
  input  logic                  enter_btn,
  input  logic [3:0]            sw,
  output logic [3:0]            d_out,
  output logic [NUM_DIGITS-1:0] load,
  output logic [2:0]            digit_idx,
  output logic                  busy,
  output logic                  done
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StEntry = 2'd1;
  localparam logic [1:0] StFull  = 2'd2;

  logic sync1_q, sync2_q;
  logic level;
  logic level_prev_q;
  logic press_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= enter_btn;
      sync2_q <= sync1_q;
    end
  end

`ifdef DIGIT_ENTRY_DEBOUNCE_EN
  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [CntW-1:0] cnt_q;
  logic            filt_q;

  // Counter restarts on any agreement, so only an unbroken run of disagreement flips the level.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else if (sync2_q == filt_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
      cnt_q  <= '0;
      filt_q <= sync2_q;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign level = filt_q;
`else
  logic unused_debounce;
  assign unused_debounce = ^DEBOUNCE_CYCLES;
  assign level           = sync2_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      level_prev_q <= 1'b0;
      press_q      <= 1'b0;
    end else begin
      level_prev_q <= level;
      press_q      <= level & ~level_prev_q;
    end
  end

  logic [1:0]            state_q, state_d;
  logic [2:0]            idx_q, idx_d;
  logic [3:0]            d_out_q, d_out_d;
  logic [NUM_DIGITS-1:0] load_q, load_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    d_out_d = d_out_q;
    load_d  = '0;
    if (clear) begin
      state_d = StIdle;
      idx_d   = 3'd0;
    end else if (start) begin
      state_d = StEntry;
      idx_d   = 3'd0;
    end else if (state_q == StEntry && press_q) begin
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
        load_d[k] = (idx_q == 3'(k));
      end
      d_out_d = sw;
      idx_d   = idx_q + 3'd1;
      if (idx_d == 3'(NUM_DIGITS)) begin
        state_d = StFull;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= 3'd0;
      d_out_q <= 4'd0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      d_out_q <= d_out_d;
      load_q  <= load_d;
    end
  end

  assign d_out     = d_out_q;
  assign load      = load_q;
  assign digit_idx = idx_q;
  assign busy      = (state_q == StEntry);
  assign done      = (state_q == StFull);

endmodule

// File: tb/tb_digit_entry_sequencer.sv
// Randomized bench for digit_entry_sequencer with an edge-indexed behavioural model of the
// button path and entry rules, plus directed literal checks from the test plan.
module tb_digit_entry_sequencer;

  localparam int unsigned ND = 4;
  localparam int unsigned DB = 16;
`ifdef DIGIT_ENTRY_DEBOUNCE_EN
  localparam bit DEB_EN = 1'b1;
`else
  localparam bit DEB_EN = 1'b0;
`endif
  localparam int LAT  = DEB_EN ? 3 + DB : 3;
  localparam int HOLD = DEB_EN ? DB + 4 : 2;
  localparam int MAXE = 32768;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          clear = 1'b0;
  logic          enter_btn = 1'b0;
  logic [3:0]    sw = 4'd0;
  logic [3:0]    d_out;
  logic [ND-1:0] load;
  logic [2:0]    digit_idx;
  logic          busy;
  logic          done;

  digit_entry_sequencer #(
    .NUM_DIGITS      (ND),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .clear     (clear),
    .enter_btn (enter_btn),
    .sw        (sw),
    .d_out     (d_out),
    .load      (load),
    .digit_idx (digit_idx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Model: raw button level and filtered level recorded per clock edge.
  bit raw_h [MAXE];
  bit filt_h[MAXE];
  int edge_n   = -1;
  int last_rst = -1;
  bit m_valid  = 1'b0;
  int m_mode   = 0;  // 0 idle, 1 entry, 2 full
  int m_idx    = 0;
  int m_dout   = 0;
  int m_load   = 0;

  function automatic bit raw_at(input int k);
    if (k < 0 || k <= last_rst) return 1'b0;
    return raw_h[k];
  endfunction

  function automatic bit filt_at(input int k);
    if (k < 0 || k <= last_rst) return 1'b0;
    return filt_h[k];
  endfunction

  // Filtered level after edge n: follows sync (= raw one edge earlier) once it has held a
  // single value for DB edges; without debounce it is simply the sync level.
  function automatic bit model_filt(input int n);
    bit v;
    if (!DEB_EN) return raw_at(n - 1);
    v = raw_at(n - 2);
    for (int k = n - int'(DB) - 1; k < n - 2; k++) begin
      if (raw_at(k) != v) return filt_at(n - 1);
    end
    return v;
  endfunction

  always @(posedge clk) begin
    bit pressed;
    edge_n++;
    if (rst) begin
      last_rst = edge_n;
      m_valid  = 1'b1;
      m_mode   = 0;
      m_idx    = 0;
      m_dout   = 0;
      m_load   = 0;
    end else begin
      raw_h[edge_n]  = enter_btn;
      filt_h[edge_n] = model_filt(edge_n);
      pressed = filt_at(edge_n - 2) && !filt_at(edge_n - 3);
      m_load  = 0;
      if (clear) begin
        m_mode = 0;
        m_idx  = 0;
      end else if (start) begin
        m_mode = 1;
        m_idx  = 0;
      end else if (m_mode == 1 && pressed) begin
        m_load = 1 << m_idx;
        m_dout = int'(sw);
        m_idx++;
        if (m_idx == int'(ND)) m_mode = 2;
      end
    end
  end

  int load_cnt = 0;

  always @(negedge clk) begin
    if (m_valid) begin
      logic [15:0] act, exp;
      act = {3'd0, d_out, load, digit_idx, busy, done};
      exp = {3'd0, 4'(m_dout), ND'(m_load), 3'(m_idx), (m_mode == 1), (m_mode == 2)};
      check("model{d_out,load,idx,busy,done}", int'(act), int'(exp));
      if (load != '0) load_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic press();
    enter_btn = 1'b1;
    repeat (HOLD) tick();
    enter_btn = 1'b0;
    repeat (HOLD + LAT) tick();
  endtask

  // Raw rise sampled at edge E; strobe must appear only after edge E+LAT, for one cycle.
  task automatic press_expect(input logic [3:0] s, input int exp_load, input int exp_dout,
                              input int exp_idx);
    sw = s;
    enter_btn = 1'b1;
    repeat (LAT) @(posedge clk);
    #1;
    check("load before latency", int'(load), 0);
    tick();
    check("load strobe", int'(load), exp_load);
    check("d_out at strobe", int'(d_out), exp_dout);
    check("digit_idx after strobe", int'(digit_idx), exp_idx);
    tick();
    check("load single cycle", int'(load), 0);
    enter_btn = 1'b0;
    repeat (HOLD + LAT) tick();
  endtask

  initial begin
    int snap;
    int hold_left;
    int first_k;
    int pulses;

    // Reset and idle
    rst = 1'b1;
    tick();
    tick();
    check("reset d_out", int'(d_out), 0);
    check("reset load", int'(load), 0);
    check("reset digit_idx", int'(digit_idx), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    rst = 1'b0;
    tick();
    snap = load_cnt;
    sw = 4'h5;
    press();
    check("idle press no load", load_cnt - snap, 0);
    check("idle press d_out", int'(d_out), 0);

    // Full entry
    pulse_start();
    check("busy after start", int'(busy), 1);
    press_expect(4'h3, 1, 3, 1);
    press_expect(4'h9, 2, 9, 2);
    press_expect(4'h0, 4, 0, 3);
    press_expect(4'hF, 8, 15, 4);
    check("full done", int'(done), 1);
    check("full busy", int'(busy), 0);
    snap = load_cnt;
    press();
    check("fifth press no load", load_cnt - snap, 0);
    check("full idx holds", int'(digit_idx), 4);

    if (DEB_EN) begin
      pulse_start();
      snap = load_cnt;
      enter_btn = 1'b1;
      repeat (10) tick();
      enter_btn = 1'b0;
      repeat (40) tick();
      check("glitch no load", load_cnt - snap, 0);
      first_k = -1;
      pulses  = 0;
      enter_btn = 1'b1;
      for (int k = 1; k <= 60; k++) begin
        tick();
        if (k == 20) enter_btn = 1'b0;
        if (load != '0) begin
          pulses++;
          if (first_k < 0) first_k = k;
        end
      end
      check("pulse load count", pulses, 1);
      check("pulse load edge", first_k, LAT + 1);
      repeat (HOLD + LAT) tick();
    end

    // Clear coincident with press at digit_idx=2
    pulse_start();
    press();
    press();
    check("idx before clear", int'(digit_idx), 2);
    enter_btn = 1'b1;
    repeat (LAT) @(posedge clk);
    #1;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear vs press load", int'(load), 0);
    check("clear vs press idx", int'(digit_idx), 0);
    check("clear vs press busy", int'(busy), 0);
    enter_btn = 1'b0;
    repeat (HOLD + LAT) tick();

    // Start coincident with press in ENTRY
    pulse_start();
    press();
    enter_btn = 1'b1;
    repeat (LAT) @(posedge clk);
    #1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start vs press load", int'(load), 0);
    check("start vs press idx", int'(digit_idx), 0);
    check("start vs press busy", int'(busy), 1);
    enter_btn = 1'b0;
    repeat (HOLD + LAT) tick();

    // Reset mid-entry
    press();
    press();
    check("idx before reset", int'(digit_idx), 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid reset idx", int'(digit_idx), 0);
    check("mid reset busy", int'(busy), 0);
    pulse_start();
    press_expect(4'h7, 1, 7, 1);

    // Randomized traffic
    hold_left = 1;
    for (int c = 0; c < 3000; c++) begin
      hold_left--;
      if (hold_left <= 0) begin
        enter_btn = ~enter_btn;
        hold_left = DEB_EN ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 6));
      end
      start = DEB_EN ? ($urandom_range(0, 299) == 0) : ($urandom_range(0, 39) == 0);
      clear = DEB_EN ? ($urandom_range(0, 599) == 0) : ($urandom_range(0, 79) == 0);
      rst   = ($urandom_range(0, 499) == 0);
      sw    = 4'($urandom);
      tick();
    end
    rst = 1'b0;
    start = 1'b0;
    clear = 1'b0;
    enter_btn = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

endmodule
